// File: rtl/mul_div_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mul_div_unit: iterative RV32M multiply/divide, one bit per clock (rev 1.0) |
// +--------------------------------------------------------------------------+
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_operand_a,
  input  logic [WIDTH-1:0] i_operand_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   counter;
  logic [2:0]         op;
  logic               neg_a;
  logic               neg_b;
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   acc_lo;
  logic [WIDTH-1:0]   opnd_b;

  logic               a_signed;
  logic               b_signed;
  logic               in_neg_a;
  logic               in_neg_b;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic               div_by_zero;
  logic               div_ovf;
  logic [WIDTH-1:0]   special_result;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH:0]     rem_diff;
  logic [2*WIDTH-1:0] product;
  logic [2*WIDTH-1:0] prod_fixed;
  logic [WIDTH-1:0]   quo_fixed;
  logic [WIDTH-1:0]   rem_fixed;
  logic [WIDTH-1:0]   fix_result;

  assign o_busy = (state != IDLE);

  // Request decode: sign handling, magnitudes and the divide short-cuts.
  always_comb begin
    a_signed       = i_op[2] ? ~i_op[0] : (i_op[1:0] != 2'b11);
    b_signed       = i_op[2] ? ~i_op[0] : ~i_op[1];
    in_neg_a       = a_signed & i_operand_a[WIDTH-1];
    in_neg_b       = b_signed & i_operand_b[WIDTH-1];
    mag_a          = in_neg_a ? -i_operand_a : i_operand_a;
    mag_b          = in_neg_b ? -i_operand_b : i_operand_b;
    div_by_zero    = i_op[2] & (i_operand_b == '0);
    div_ovf        = i_op[2] & ~i_op[0] & (i_operand_a == MIN_INT) & (i_operand_b == '1);
    special_result = '0;
    if (div_by_zero) begin
      special_result = i_op[1] ? i_operand_a : '1;
    end else if (div_ovf) begin
      special_result = i_op[1] ? '0 : i_operand_a;
    end
  end

  // acc_hi holds the partial product high half or the running remainder;
  // acc_lo holds the multiplier being shifted out or the quotient shifting in.
  always_comb begin
    mul_sum    = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_b} : '0);
    rem_shift  = {acc_hi, acc_lo[WIDTH-1]};
    rem_diff   = rem_shift - {1'b0, opnd_b};
    product    = {acc_hi, acc_lo};
    prod_fixed = (neg_a ^ neg_b) ? -product : product;
    quo_fixed  = (neg_a ^ neg_b) ? -acc_lo : acc_lo;
    rem_fixed  = neg_a ? -acc_hi : acc_hi;
    if (op[2]) begin
      fix_result = op[1] ? rem_fixed : quo_fixed;
    end else begin
      fix_result = (op[1:0] == 2'b00) ? prod_fixed[WIDTH-1:0] : prod_fixed[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      counter  <= '0;
      o_done   <= 1'b0;
      o_result <= '0;
      op       <= '0;
      neg_a    <= 1'b0;
      neg_b    <= 1'b0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      opnd_b   <= '0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            op      <= i_op;
            neg_a   <= in_neg_a;
            neg_b   <= in_neg_b;
            counter <= '0;
            acc_hi  <= '0;
            if (div_by_zero || div_ovf) begin
              o_result <= special_result;
              o_done   <= 1'b1;
              state    <= DONE;
            end else begin
              acc_lo <= i_op[2] ? mag_a : mag_b;
              opnd_b <= i_op[2] ? mag_b : mag_a;
              state  <= CALC;
            end
          end
        end
        CALC: begin
          counter <= counter + CNT_W'(1);
          if (op[2]) begin
            // Restoring step: keep the subtraction only when it did not borrow.
            if (!rem_diff[WIDTH]) begin
              acc_hi <= rem_diff[WIDTH-1:0];
              acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
              acc_hi <= rem_shift[WIDTH-1:0];
              acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc_hi <= mul_sum[WIDTH:1];
            acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
          end
          if (counter == LAST_ITER) begin
            state <= FIX;
          end
        end
        FIX: begin
          o_result <= fix_result;
          o_done   <= 1'b1;
          state    <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
